prog_counter: RTL and testbench



---
 rtl/prog_counter_pkg.sv | 20 ++
 rtl/prog_counter_prescaler.sv | 38 +++
 rtl/prog_counter.sv | 142 ++++++++++++++
 tb/tb_prog_counter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_counter_pkg.sv
// Shared types and constants for prog_counter and its prescaler.
// Imported by every file in the block.
package prog_counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_counter_prescaler.sv
// Step-enable divider: strobes on every (prescale_i+1)-th qualifying cycle.
// Combinational strobe from a registered divide count; clear_i restarts the spacing.
module prog_counter_prescaler
    import prog_counter_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  qual_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  step_o
);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    always_comb begin
        // >= so that lowering prescale_i mid-count never runs past the target
        step_o = qual_i && (cnt_q >= prescale_i);
        cnt_d  = cnt_q;
        if (clear_i || step_o) begin
            cnt_d = '0;
        end else if (qual_i) begin
            cnt_d = cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down event counter with wrap/saturate/one-shot modes and run FSM; count/tc/busy/done registered (1 cycle).
// PROG_COUNTER_PRESCALE_EN adds a step prescaler (parameter PRESCALE_W, input prescale).
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef PROG_COUNTER_PRESCALE_EN
    ,
    parameter int               PRESCALE_W = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
`ifdef PROG_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             nonzero,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             busy_q;
    logic             done_q;
    // Last step landed on the terminal value; suppresses repeat tc while holding there
    logic             hit_q;

    logic             run_qual;
    logic             step;
    logic             is_wrap;
    logic             is_oneshot;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_clip;
    logic             at_term;
    logic             tc_d;

    always_comb begin
        run_qual   = (state_q == ST_RUN) && enable && !load && !stop && !start;
        is_oneshot = (mode == MODE_ONESHOT);
        is_wrap    = !((mode == MODE_SAT) || is_oneshot);
        term_val   = (dir == DIR_DOWN) ? '0 : limit;
        load_clip  = (load_val > limit) ? limit : load_val;

        count_d = count_q;
        if (dir == DIR_UP) begin
            if (count_q < limit) begin
                count_d = count_q + WIDTH'(1);
            end else begin
                count_d = is_wrap ? '0 : limit;
            end
        end else begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                count_d = is_wrap ? limit : '0;
            end
        end

        at_term = (count_d == term_val);
        tc_d    = step && at_term && (is_wrap || !hit_q);
    end

`ifdef PROG_COUNTER_PRESCALE_EN
    prog_counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (load | start | stop),
        .qual_i     (run_qual),
        .prescale_i (prescale),
        .step_o     (step)
    );
`else
    assign step = run_qual;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (load) begin
                count_q <= load_clip;
                done_q  <= 1'b0;
                hit_q   <= 1'b0;
                if (state_q == ST_DONE) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            end else if (stop) begin
                if (state_q == ST_RUN) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    hit_q   <= 1'b0;
                end
            end else if (start) begin
                if (state_q != ST_RUN) begin
                    state_q <= ST_RUN;
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    hit_q   <= 1'b0;
                end
            end else if (step) begin
                count_q <= count_d;
                hit_q   <= at_term;
                tc_q    <= tc_d;
                if (tc_d && is_oneshot) begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign count   = count_q;
    assign nonzero = |count_q;
    assign tc      = tc_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: behavioural model checked every cycle plus directed literal expectations.
module tb_prog_counter;

    logic       clk;
    logic       reset;
    logic       enable, start, stop, dir, load;
    logic [1:0] mode;
    logic [7:0] load_val, limit;
    logic [7:0] count;
    logic       nonzero, tc, busy, done;
`ifdef PROG_COUNTER_PRESCALE_EN
    logic [3:0] prescale;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    prog_counter #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
`ifdef PROG_COUNTER_PRESCALE_EN
        .prescale (prescale),
`endif
        .count    (count),
        .nonzero  (nonzero),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_count;
    bit m_run, m_done, m_tc, m_announced;
    int m_pre;

    always @(posedge clk or posedge reset) begin
        int lim, nxt, term, psv;
        bit wrap, qual, do_step;
        if (reset) begin
            m_count = 0; m_run = 0; m_done = 0; m_tc = 0; m_announced = 0; m_pre = 0;
        end else begin
            lim  = int'(limit);
            wrap = !(mode == 2'b01 || mode == 2'b10);
`ifdef PROG_COUNTER_PRESCALE_EN
            psv = int'(prescale);
`else
            psv = 0;
`endif
            m_tc = 0;
            qual = m_run && enable && !load && !stop && !start;
            if (load) begin
                m_count     = (int'(load_val) > lim) ? lim : int'(load_val);
                m_done      = 0;
                m_announced = 0;
            end else if (stop) begin
                if (m_run) begin m_run = 0; m_announced = 0; end
            end else if (start) begin
                if (!m_run) begin m_run = 1; m_done = 0; m_announced = 0; end
            end
            if (load || start || stop) m_pre = 0;
            do_step = 0;
            if (qual) begin
                m_pre++;
                if (m_pre == psv + 1) begin do_step = 1; m_pre = 0; end
            end
            if (do_step) begin
                if (dir == 1'b0) nxt = (m_count < lim) ? m_count + 1 : (wrap ? 0 : lim);
                else             nxt = (m_count > 0) ? m_count - 1 : (wrap ? lim : 0);
                term = (dir == 1'b0) ? lim : 0;
                if (nxt == term && (wrap || !m_announced)) begin
                    m_tc = 1;
                    if (mode == 2'b10) begin m_run = 0; m_done = 1; end
                end
                m_announced = (nxt == term);
                m_count     = nxt;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cmp_count",   count,   m_count);
            check("cmp_tc",      tc,      m_tc);
            check("cmp_busy",    busy,    m_run);
            check("cmp_done",    done,    m_done);
            check("cmp_nonzero", nonzero, m_count != 0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int exp1[8]   = '{0, 1, 2, 3, 4, 5, 0, 1};
    int exp2[6]   = '{3, 2, 1, 0, 0, 0};
    int exp2tc[6] = '{0, 0, 0, 1, 0, 0};

    initial begin
        reset = 1'b0; enable = 0; start = 0; stop = 0; dir = 0; load = 0;
        mode = 2'b00; load_val = 8'd0; limit = 8'd5;
`ifdef PROG_COUNTER_PRESCALE_EN
        prescale = 4'd0;
`endif
        #1 reset = 1'b1;
        #1 cmp_on = 1;
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_busy",  busy,  0);
        check("rst_tc",    tc,    0);
        check("rst_done",  done,  0);
        reset = 1'b0;
        tick();

        // wrap up, limit 5
        start = 1; enable = 1;
        tick();
        start = 0;
        check("wrap_start_count", count, exp1[0]);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("wrap_count", count, exp1[i]);
            check("wrap_tc",    tc,    exp1[i] == 5);
            check("wrap_busy",  busy,  1);
        end

        // saturate down from 3
        stop = 1; enable = 0; tick(); stop = 0;
        mode = 2'b01; dir = 1; load = 1; load_val = 8'd3; tick(); load = 0;
        start = 1; enable = 1; tick(); start = 0;
        check("sat_start_count", count, exp2[0]);
        for (int i = 1; i < 6; i++) begin
            tick();
            check("sat_count",   count,   exp2[i]);
            check("sat_tc",      tc,      exp2tc[i]);
            check("sat_nonzero", nonzero, exp2[i] != 0);
        end

        // one-shot up to 3
        stop = 1; tick(); stop = 0;
        mode = 2'b10; dir = 0; limit = 8'd3; load = 1; load_val = 8'd0; tick(); load = 0;
        start = 1; tick(); start = 0;
        tick(); tick(); tick();
        check("os_count", count, 3);
        check("os_tc",    tc,    1);
        check("os_done",  done,  1);
        check("os_busy",  busy,  0);
        tick();
        check("os_hold_count", count, 3);
        check("os_hold_tc",    tc,    0);
        start = 1; tick(); start = 0;
        check("os_restart_done", done, 0);
        check("os_restart_busy", busy, 1);
        tick();
        check("os_again_count", count, 3);
        check("os_again_tc",    tc,    1);
        check("os_again_done",  done,  1);
        load = 1; load_val = 8'd1; tick(); load = 0;
        check("os_load_count", count, 1);
        check("os_load_done",  done,  0);
        check("os_load_busy",  busy,  0);

        // load beats start and step; value clipped to limit
        start = 1; tick(); start = 0;
        mode = 2'b00; limit = 8'd100; load = 1; start = 1; load_val = 8'd200;
        tick(); load = 0; start = 0;
        check("clip_count", count, 100);
        check("clip_busy",  busy,  1);
        check("clip_tc",    tc,    0);
        tick();
        check("clip_wrap_count", count, 0);
        repeat (7) tick();
        check("run7_count", count, 7);

        // async reset mid-run
        reset = 1; #1;
        check("arst_count", count, 0);
        check("arst_busy",  busy,  0);
        check("arst_tc",    tc,    0);
        tick(); reset = 0;
        tick(); tick();
        check("post_rst_count", count, 0);
        check("post_rst_busy",  busy,  0);

        // limit 0: wrap pulses every step, saturate once
        limit = 8'd0; start = 1; tick(); start = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lim0_wrap_tc", tc, 1);
        end
        stop = 1; tick(); stop = 0;
        mode = 2'b01; start = 1; tick(); start = 0;
        tick(); check("lim0_sat_tc1", tc, 1);
        tick(); check("lim0_sat_tc2", tc, 0);

        // wrap down through 0 to limit
        stop = 1; tick(); stop = 0;
        mode = 2'b00; dir = 1; limit = 8'd4; load = 1; load_val = 8'd1; tick(); load = 0;
        start = 1; tick(); start = 0;
        tick(); check("down_count0", count, 0); check("down_tc0", tc, 1);
        tick(); check("down_count4", count, 4); check("down_tc4", tc, 0);
        tick(); check("down_count3", count, 3);

`ifdef PROG_COUNTER_PRESCALE_EN
        stop = 1; tick(); stop = 0;
        dir = 0; limit = 8'd100; load = 1; load_val = 8'd0; tick(); load = 0;
        prescale = 4'd2; start = 1; tick(); start = 0;
        begin
            int exp_ps[6] = '{0, 0, 1, 1, 1, 2};
            for (int i = 0; i < 6; i++) begin
                tick();
                check("ps_count", count, exp_ps[i]);
            end
        end
        stop = 1; tick(); stop = 0;
        start = 1; tick(); start = 0;
        tick(); check("ps_rs_count_a", count, 2);
        tick(); check("ps_rs_count_b", count, 2);
        tick(); check("ps_rs_count_c", count, 3);
        prescale = 4'd0;
`endif

        enable = 0;
        tick(); tick();
        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
